// File: rtl/gray_counter_if.sv
// Bus bundle for gray_counter.
// The err signal exists only when GRAY_CNT_CHECK_EN is defined.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             upd;
  logic             tc;
  logic             wrap;
`ifdef GRAY_CNT_CHECK_EN
  logic             err;
`endif

  // Driver side: issues count/load requests and observes the count.
  modport master (
    output en, up_dn, load, load_val,
`ifdef GRAY_CNT_CHECK_EN
    input  err,
`endif
    input  bin_q, gray_q, upd, tc, wrap
  );

  // Counter side.
  modport slave (
    input  en, up_dn, load, load_val,
`ifdef GRAY_CNT_CHECK_EN
    output err,
`endif
    output bin_q, gray_q, upd, tc, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered binary up/down counter with a flop-aligned Gray-coded copy.
// Optional Gray single-step checker enabled by defining GRAY_CNT_CHECK_EN.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             upd_q, upd_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_val;

  // Next state: load beats count; Gray is encoded from the next binary value.
  always_comb begin
    bin_d    = bin_q;
    upd_d    = 1'b0;
    wrap_d   = 1'b0;
    step_val = bus.up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);
    if (bus.load) begin
      bin_d = bus.load_val;
      upd_d = 1'b1;
    end else if (bus.en) begin
      bin_d  = step_val;
      upd_d  = 1'b1;
      wrap_d = bus.up_dn ? (bin_q == AllOnes) : (bin_q == '0);
    end
    gray_d = to_gray(bin_d);
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      upd_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      upd_q  <= upd_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin_q  = bin_q;
  assign bus.gray_q = gray_q;
  assign bus.upd    = upd_q;
  assign bus.wrap   = wrap_q;
  // Terminal count follows up_dn immediately.
  assign bus.tc     = bus.up_dn ? (bin_q == AllOnes) : (bin_q == '0);

`ifdef GRAY_CNT_CHECK_EN
  function automatic int unsigned ones(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             was_load_q, was_load_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  // Checker next state: compare the visible Gray change against its predecessor.
  // armed_q skips the first update after reset.
  always_comb begin
    prev_gray_d = gray_q;
    was_load_d  = bus.load;
    armed_d     = armed_q | upd_q;
    err_d       = err_q;
    if (upd_q && armed_q && !was_load_q && (ones(gray_q ^ prev_gray_q) != 1)) begin
      err_d = 1'b1;
    end
  end

  // Checker registers; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      was_load_q  <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      was_load_q  <= was_load_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at WIDTH = 4.
module tb_gray_counter;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  gray_counter_if #(.WIDTH(WIDTH)) bus ();

  gray_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gray_tab [4];

  initial begin
    gray_tab[0] = 4'b0001;
    gray_tab[1] = 4'b0011;
    gray_tab[2] = 4'b0010;
    gray_tab[3] = 4'b0110;
    n_cmp = 0;
    n_bad = 0;

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    step();
    step();
    check_eq("rst_bin", 32'(bus.bin_q), 32'd0);
    check_eq("rst_gray", 32'(bus.gray_q), 32'd0);
    check_eq("rst_upd", 32'(bus.upd), 32'd0);
    check_eq("rst_wrap", 32'(bus.wrap), 32'd0);

    // Count up 1..4.
    rst_n  = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("up_bin%0d", i), 32'(bus.bin_q), 32'(i + 1));
      check_eq($sformatf("up_gray%0d", i), 32'(bus.gray_q), 32'(gray_tab[i]));
      check_eq($sformatf("up_upd%0d", i), 32'(bus.upd), 32'd1);
      check_eq($sformatf("up_wrap%0d", i), 32'(bus.wrap), 32'd0);
    end

    // Load 15, then wrap upward.
    bus.en       = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd15;
    step();
    check_eq("ld15_bin", 32'(bus.bin_q), 32'd15);
    check_eq("ld15_gray", 32'(bus.gray_q), 32'b1000);
    check_eq("ld15_upd", 32'(bus.upd), 32'd1);
    check_eq("ld15_wrap", 32'(bus.wrap), 32'd0);
    check_eq("ld15_tc", 32'(bus.tc), 32'd1);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    step();
    check_eq("wrapup_bin", 32'(bus.bin_q), 32'd0);
    check_eq("wrapup_gray", 32'(bus.gray_q), 32'd0);
    check_eq("wrapup_wrap", 32'(bus.wrap), 32'd1);
    check_eq("wrapup_tc", 32'(bus.tc), 32'd0);

    // Flip direction at 0: tc responds combinationally, then wrap downward.
    bus.en    = 1'b0;
    bus.up_dn = 1'b0;
    #1;
    check_eq("dn_tc0", 32'(bus.tc), 32'd1);
    bus.en = 1'b1;
    step();
    check_eq("wrapdn_bin", 32'(bus.bin_q), 32'd15);
    check_eq("wrapdn_gray", 32'(bus.gray_q), 32'b1000);
    check_eq("wrapdn_wrap", 32'(bus.wrap), 32'd1);
    check_eq("wrapdn_tc", 32'(bus.tc), 32'd0);
    step();
    check_eq("dn14_bin", 32'(bus.bin_q), 32'd14);
    check_eq("dn14_gray", 32'(bus.gray_q), 32'b1001);
    check_eq("dn14_wrap", 32'(bus.wrap), 32'd0);
    bus.en = 1'b0;
    step();
    check_eq("hold_bin", 32'(bus.bin_q), 32'd14);
    check_eq("hold_upd", 32'(bus.upd), 32'd0);
    check_eq("hold_wrap", 32'(bus.wrap), 32'd0);

    // Load and en together: load wins.
    bus.load     = 1'b1;
    bus.en       = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load_val = 4'd5;
    step();
    check_eq("ldwin_bin", 32'(bus.bin_q), 32'd5);
    check_eq("ldwin_gray", 32'(bus.gray_q), 32'b0111);
    check_eq("ldwin_wrap", 32'(bus.wrap), 32'd0);
    check_eq("ldwin_upd", 32'(bus.upd), 32'd1);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    step();
    check_eq("ldhold_bin", 32'(bus.bin_q), 32'd5);
    check_eq("ldhold_upd", 32'(bus.upd), 32'd0);

    // Reset at 9 with en high overrides the step.
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    step();
    check_eq("ld9_bin", 32'(bus.bin_q), 32'd9);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    rst_n    = 1'b0;
    step();
    check_eq("midrst_bin", 32'(bus.bin_q), 32'd0);
    check_eq("midrst_gray", 32'(bus.gray_q), 32'd0);
    check_eq("midrst_upd", 32'(bus.upd), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("resume_bin", 32'(bus.bin_q), 32'd1);
    check_eq("resume_gray", 32'(bus.gray_q), 32'b0001);

`ifdef GRAY_CNT_CHECK_EN
    // Random steps with interleaved loads must never flag an error.
    for (int i = 0; i < 40; i++) begin
      bus.en       = 1'($urandom_range(1));
      bus.up_dn    = 1'($urandom_range(1));
      bus.load     = ($urandom_range(7) == 0);
      bus.load_val = 4'($urandom_range(15));
      step();
    end
    bus.load = 1'b0;
    bus.en   = 1'b0;
    step();
    check_eq("rand_err", 32'(bus.err), 32'd0);

    // Count twice, then corrupt the visible Gray value by two bits.
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    step();
    step();
    bus.en = 1'b0;
    force dut.gray_q = dut.prev_gray_q ^ 4'b0011;
    step();
    release dut.gray_q;
    check_eq("jump_err", 32'(bus.err), 32'd1);
    step();
    step();
    check_eq("sticky_err", 32'(bus.err), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("clr_err", 32'(bus.err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

- Registered binary up/down counter that produces both the binary count and its Gray-coded equivalent, aligned in the same cycle.
- Sits directly upstream of the binary-to-Gray conversion path. It supplies the pointer/sequence values that downstream logic needs in Gray form, such as FIFO pointers and position counters.
- Gray output comes straight from a flop, so it is glitch-free and safe to hand to other consumers.

## Interface

Parameters:
- WIDTH, 4, counter and Gray width in bits (legal range 2–32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  count enable; one step per cycle while high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  binary value to load
- bin_q  output  WIDTH  registered binary count
- gray_q  output  WIDTH  registered Gray code of bin_q
- upd  output  1  one-cycle pulse: bin_q/gray_q changed this cycle
- tc  output  1  terminal count, combinational from bin_q and up_dn
- wrap  output  1  one-cycle pulse: last step wrapped around
- err  output  1  sticky Gray-step error; present only with GRAY_CNT_CHECK_EN

## Operation

- Next-state priority, evaluated each rising clk edge:
  1. rst_n low: bin_q = 0, gray_q = 0, upd = 0, wrap = 0, err = 0.
  2. load high: bin_q = load_val, gray_q = gray(load_val), upd = 1, wrap = 0. en is ignored.
  3. en high: bin_q = bin_q ± 1 modulo 2^WIDTH, gray_q = gray(next bin), upd = 1. wrap = 1 if the step went all-ones→0 (up) or 0→all-ones (down).
  4. Otherwise: hold; upd = 0, wrap = 0.
- Gray rule: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i] ^ b[i+1] for i < WIDTH-1.
- gray_q is computed from the next binary value and registered on the same edge as bin_q. It is never derived combinationally from bin_q.
- tc = up_dn ? (bin_q == all-ones) : (bin_q == 0). tc is combinational, so it changes immediately when up_dn toggles.
- Direction may change on any cycle. The step taken uses the up_dn value sampled at that edge.
- A count step (no load) changes exactly one bit of gray_q, including across wrap.
- A load may change any number of Gray bits.

## Timing

- Latency: 1 cycle from an en/load sample to updated bin_q/gray_q/upd/wrap.
- Throughput: one step per cycle, with no stall.
- Reset: synchronous. Outputs read 0 from the first edge at which rst_n is sampled low.
- Reset mid-count overrides load and en in that cycle.
- Counting resumes on the first edge with rst_n high and en high; the first step from 0 gives bin_q = 1 (up) or all-ones (down).
- If load and en are both high, load wins. Exactly one value update occurs and wrap = 0.
- If en is held high, upd stays high every cycle.

## Configuration

- GRAY_CNT_CHECK_EN defined:
  - Adds a registered copy of the previous gray_q and the err output.
  - err is set when a cycle with upd = 1 that was not caused by load changes a number of gray_q bits other than one.
  - The check is skipped on the first update after reset.
  - Once set, err stays high until reset.
- GRAY_CNT_CHECK_EN undefined:
  - err port and checker logic are absent.
  - All other behaviour is identical.

## Test plan

With WIDTH = 4:
- Reset, then en = 1, up_dn = 1 for 4 cycles → bin_q 1, 2, 3, 4; gray_q 0001, 0011, 0010, 0110; upd high each cycle; wrap 0.
- load = 1, load_val = 15, then en = 1, up_dn = 1 → tc = 1 while bin_q = 15. Next edge gives bin_q 0, gray_q 1000→0000, wrap pulses 1 cycle.
- From bin_q = 0, en = 1, up_dn = 0 → tc = 1 before the step. After the step bin_q = 15, gray_q = 1000, wrap = 1.
- load = 1 and en = 1 in the same cycle with load_val = 5 → bin_q = 5, gray_q = 0111, wrap = 0. en = 0 afterwards → value holds and upd = 0.
- Assert rst_n = 0 mid-count at bin_q = 9 with en = 1 → next edge bin_q = 0, gray_q = 0, upd = 0. Release rst_n → first step gives bin_q = 1.
- GRAY_CNT_CHECK_EN defined:
  - 40 random en/up_dn cycles with interleaved loads → err stays 0.
  - Force a 2-bit Gray jump without load → err rises next cycle and stays high until reset.
